// File: rtl/mul_add_seq_if.sv
// mul_add_seq_if: operand/result valid-ready bus for the shift-add multiply-accumulate unit.
//   in_vld/in_rdy        operand handshake (multiplicand, multiplier, addend, DW bits each)
//   out_vld/out_rdy      result handshake (product, 2*DW bits)
//   master: operand source / result sink; slave: the arithmetic unit
interface mul_add_seq_if #(parameter int DW = 8);
    logic            in_vld;
    logic            in_rdy;
    logic [DW-1:0]   multiplicand;
    logic [DW-1:0]   multiplier;
    logic [DW-1:0]   addend;
    logic            out_vld;
    logic            out_rdy;
    logic [2*DW-1:0] product;
    modport master (
        output in_vld, multiplicand, multiplier, addend, out_rdy,
        input  in_rdy, out_vld, product
    );
    modport slave (
        input  in_vld, multiplicand, multiplier, addend, out_rdy,
        output in_rdy, out_vld, product
    );
endinterface

// File: rtl/mul_add_seq.sv
// mul_add_seq: sequential shift-add product = multiplicand * multiplier + addend, one multiplier bit per clock.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   mul_add_seq_if.slave: operand handshake in, 2*DW-bit product handshake out
// Latency is fixed at DW cycles from the accepting edge to out_vld; the result
// is the reconstruction path of the sequential divider (q*d+r == dividend).
module mul_add_seq #(
    parameter int DW = 8
) (
    input  logic           clk,
    input  logic           rst,
    mul_add_seq_if.slave   bus
);
    localparam int CW = $clog2(DW) + 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t          state;
    logic [2*DW-1:0] acc;
    logic [2*DW-1:0] mcand;
    logic [2*DW-1:0] acc_nxt;
    logic [DW-1:0]   mplier;
    logic [CW-1:0]   cnt;
    logic            in_rdy_q;
    logic            out_vld_q;
    logic [2*DW-1:0] product_q;
    // Addend preloads the accumulator, so the final sum never exceeds 2^(2DW)-2^DW.
    assign acc_nxt     = mplier[0] ? acc + mcand : acc;
    assign bus.in_rdy  = in_rdy_q;
    assign bus.out_vld = out_vld_q;
    assign bus.product = product_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            product_q <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_vld) begin
                    acc      <= {{DW{1'b0}}, bus.addend};
                    mcand    <= {{DW{1'b0}}, bus.multiplicand};
                    mplier   <= bus.multiplier;
                    cnt      <= '0;
                    in_rdy_q <= 1'b0;
                    state    <= BUSY;
                end
                BUSY: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    // Last multiplier bit: publish the sum including this step.
                    if (cnt == CW'(DW - 1)) begin
                        product_q <= acc_nxt;
                        out_vld_q <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (bus.out_rdy) begin
                    out_vld_q <= 1'b0;
                    in_rdy_q  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_add_seq.sv
// tb_mul_add_seq: randomized and directed check of mul_add_seq against plain A*B+C arithmetic.
module tb_mul_add_seq;
    localparam int DW = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    mul_add_seq_if #(.DW(DW)) bus ();
    mul_add_seq #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                         input int hold, input bit junk);
        int unsigned exp;
        int n;
        exp = 32'(a) * 32'(b) + 32'(c);
        n = 0;
        while (bus.in_rdy !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        check("rdy_wait", 32'(bus.in_rdy), 1);
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.addend       = c;
        bus.in_vld       = 1'b1;
        tick;
        check("accept_rdy", 32'(bus.in_rdy), 0);
        if (junk) begin
            bus.multiplicand = 1;
            bus.multiplier   = 1;
            bus.addend       = 1;
        end else bus.in_vld = 1'b0;
        n = 0;
        while (bus.out_vld !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        check("latency", 32'(n), 32'(DW));
        check("product", 32'(bus.product), exp);
        for (int i = 0; i < hold; i++) begin
            tick;
            check("hold_vld", 32'(bus.out_vld), 1);
            check("hold_prod", 32'(bus.product), exp);
            check("hold_rdy", 32'(bus.in_rdy), 0);
        end
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        tick;
        bus.out_rdy = 1'b0;
        check("hs_vld", 32'(bus.out_vld), 0);
        check("hs_rdy", 32'(bus.in_rdy), 1);
        check("keep_prod", 32'(bus.product), exp);
        if (junk) begin
            for (int i = 0; i < 3; i++) begin
                tick;
                check("no_second", 32'(bus.out_vld), 0);
                check("idle_rdy", 32'(bus.in_rdy), 1);
            end
        end
    endtask
    initial begin
        int n, t_vld, t_acc;
        bit seen_rdy;
        bus.in_vld = 1'b0;
        bus.out_rdy = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        bus.addend = '0;
        tick;
        tick;
        check("rst_vld", 32'(bus.out_vld), 0);
        check("rst_prod", 32'(bus.product), 0);
        check("rst_rdy", 32'(bus.in_rdy), 1);
        rst = 1'b0;
        bus.out_rdy = 1'b1;
        tick;
        bus.out_rdy = 1'b0;
        check("idle_ordy", 32'(bus.out_vld), 0);
        do_op(8'd13, 8'd11, 8'd7, 0, 1'b0);
        do_op(8'd255, 8'd255, 8'd255, 0, 1'b0);
        do_op(8'd255, 8'd255, 8'd0, 1, 1'b0);
        do_op(8'd0, 8'd200, 8'd0, 0, 1'b0);
        do_op(8'd200, 8'd0, 8'd45, 0, 1'b0);
        do_op(8'd13, 8'd11, 8'd7, 5, 1'b1);
        bus.multiplicand = 8'd100;
        bus.multiplier   = 8'd100;
        bus.addend       = 8'd0;
        bus.in_vld       = 1'b1;
        tick;
        bus.in_vld = 1'b0;
        tick;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst_vld", 32'(bus.out_vld), 0);
        check("midrst_prod", 32'(bus.product), 0);
        check("midrst_rdy", 32'(bus.in_rdy), 1);
        for (int i = 0; i < DW + 2; i++) begin
            tick;
            check("midrst_quiet", 32'(bus.out_vld), 0);
        end
        do_op(8'd3, 8'd4, 8'd1, 0, 1'b0);
        bus.multiplicand = 8'd57;
        bus.multiplier   = 8'd4;
        bus.addend       = 8'd1;
        bus.out_rdy      = 1'b1;
        bus.in_vld       = 1'b1;
        tick;
        bus.multiplicand = 8'd12;
        bus.multiplier   = 8'd9;
        bus.addend       = 8'd3;
        t_vld = -1;
        t_acc = -1;
        seen_rdy = 1'b0;
        n = 0;
        while (t_acc < 0 && n < 40) begin
            tick;
            n++;
            if (bus.out_vld === 1'b1 && t_vld < 0) begin
                t_vld = n;
                check("b2b_prod0", 32'(bus.product), 32'(57 * 4 + 1));
            end
            if (bus.in_rdy === 1'b1) seen_rdy = 1'b1;
            else if (seen_rdy) t_acc = n;
        end
        bus.in_vld = 1'b0;
        check("b2b_lat0", 32'(t_vld), 32'(DW));
        check("b2b_gap", 32'(t_acc), 32'(DW + 2));
        n = 0;
        while (bus.out_vld !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        check("b2b_lat1", 32'(n), 32'(DW));
        check("b2b_prod1", 32'(bus.product), 32'(12 * 9 + 3));
        tick;
        bus.out_rdy = 1'b0;
        check("b2b_hs", 32'(bus.out_vld), 0);
        for (int i = 0; i < 25; i++)
            do_op(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)),
                  DW'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_add_seq.md
Name: mul_add_seq

Overview:
- Sequential shift-add multiply-accumulate: computes product = multiplicand * multiplier + addend, one multiplier bit per clock.
- Inverse of the team's sequential divider. Feeding it quotient, divisor and remainder must reproduce the dividend, so it serves as the divider's reconstruction and check path.
- Valid/ready on both input and output.
- Single clock domain; sits beside the divider in the arithmetic datapath.

Parameters:
- DW, 8, operand width in bits. Legal range DW >= 2; the product is 2*DW bits.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_vld  input  1  operands valid.
- in_rdy  output  1  block can accept operands. High only in IDLE.
- multiplicand  input  DW  unsigned operand A.
- multiplier  input  DW  unsigned operand B.
- addend  input  DW  unsigned operand C.
- out_vld  output  1  product valid; held until accepted.
- out_rdy  input  1  downstream accepts product.
- product  output  2*DW  A*B+C, unsigned.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - rst sampled high at a clock edge forces state=IDLE, out_vld=0, product=0, and clears the counter and internal registers.
  - in_rdy=1 from the cycle after that edge.
  - rst overrides all other inputs, including mid-operation; any partial result is discarded.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_rdy=1, out_vld=0.
  - in_vld=1 at an edge accepts the operands and goes to BUSY.
  - Accept registers: acc = {DW zeros, addend}; mcand = {DW zeros, multiplicand}; mplier = multiplier; cnt = 0.
- BUSY:
  - in_rdy=0; in_vld is ignored and operand inputs may change freely.
  - Each edge: if mplier[0], acc = acc + mcand (2*DW-bit add).
  - Then mcand shifts left 1, mplier shifts right 1, cnt increments.
  - The edge that processes the DW-th bit (cnt == DW-1) loads product <= final acc, sets out_vld=1 and goes to DONE.
- DONE:
  - in_rdy=0; out_vld=1; product held stable.
  - out_rdy=1 at an edge completes the handshake: out_vld=0, state=IDLE.
  - New operands are not accepted in DONE, so there is no same-cycle accept.
- Latency and throughput:
  - out_vld rises exactly DW cycles after the accepting edge.
  - With out_rdy tied high, one operation every DW+2 cycles: accept, DW BUSY edges, 1 DONE edge.
- product after handshake: keeps its last value until the next completion. Only out_vld qualifies it.
- Width rule: max result (2^DW-1)^2 + (2^DW-1) = 2^(2DW) - 2^DW, which fits in 2*DW bits. No overflow is possible and no saturation is required.
- Counter width: $clog2(DW)+1 bits.
- Zero operands:
  - multiplier=0 skips no cycles; latency is constant at DW regardless of operand values.
  - multiplicand=0 gives product=addend.
- out_rdy high while out_vld=0 has no effect.

Test Plan (DW=8):
- Basic MAC: accept A=13, B=11, C=7 at edge E0 → out_vld=1 after edge E8, product=16'h0096 (150). Handshake at E9 → in_rdy=1 after E9.
- Max values: A=255, B=255, C=255 → product=16'hFF00. Also A=255, B=255, C=0 → 16'hFE01.
- Zero cases: A=0, B=200, C=0 → 16'h0000. A=200, B=0, C=45 → 16'h002D. Both must show the same 8-cycle latency.
- Backpressure and ignored input: out_rdy held low 5 cycles after out_vld → out_vld and product=16'h0096 stable throughout. in_vld pulsed with A=1, B=1, C=1 during BUSY and DONE → not accepted, in_rdy=0, no second result.
- Reset mid-op: accept A=100, B=100, C=0; assert rst for 1 cycle at the 4th BUSY edge → next cycle out_vld=0, product=0, in_rdy=1. Then A=3, B=4, C=1 → product=16'h000D after 8 cycles.
- Back-to-back and divider inverse: in_vld held high, out_rdy tied high, ops (57,4,1) then (12,9,3) → products 16'h00E5 (229) and 16'h006F (111). Accepts 10 cycles apart; 229 = 57*4+1 matches divider output for 229/4.
